fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_parts.sv | 49 ++++
 rtl/fetch_stage.sv | 51 +++++
 tb/tb_fetch_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared datapath constants for the LEGv8 pipeline stages.
// Decode, execute and memory import the same width and reset PC from here.
package fetch_stage_pkg;

  localparam int unsigned N = 64;
  localparam logic [N-1:0] PC_INC   = 64'd4;
  localparam logic [N-1:0] RESET_PC = '0;

  typedef enum logic {
    PC_SEQ    = 1'b0,
    PC_BRANCH = 1'b1
  } pc_src_e;

endpackage

// File: rtl/fetch_stage_parts.sv
// Generic datapath building blocks used by the fetch stage:
// a resettable register, an adder and a 2:1 mux.

module flopr #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= RESET_VAL;
    else         data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

module adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  // Carry out is intentionally dropped: sum wraps modulo 2^WIDTH.
  assign sum_o = a_i + b_i;

endmodule

module mux2 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register driving imem, updated each edge with
// PC+PC_INC or the branch target from execute. Pure wiring of flopr/adder/mux2.

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned  N        = fetch_stage_pkg::N,
  parameter logic [N-1:0] PC_INC   = fetch_stage_pkg::PC_INC,
  parameter logic [N-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic         PCSrc_F,
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PCBranch_F,
  output logic [N-1:0] imem_addr_F
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_plus_inc;
  logic [N-1:0] pc_d;

  flopr #(
    .WIDTH     (N),
    .RESET_VAL (RESET_PC)
  ) pc_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (pc_d),
    .q_o     (pc_q)
  );

  adder #(
    .WIDTH (N)
  ) pc_adder (
    .a_i   (pc_q),
    .b_i   (PC_INC),
    .sum_o (pc_plus_inc)
  );

  mux2 #(
    .WIDTH (N)
  ) pc_mux (
    .d0_i  (pc_plus_inc),
    .d1_i  (PCBranch_F),
    .sel_i (PCSrc_F == PC_BRANCH),
    .y_o   (pc_d)
  );

  assign imem_addr_F = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then random traffic checked every cycle against a PC model.

module tb_fetch_stage;

  localparam int unsigned W = 64;

  logic         clk;
  logic         reset;
  logic         PCSrc_F;
  logic [W-1:0] PCBranch_F;
  logic [W-1:0] imem_addr_F;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [W-1:0] exp_pc;
  bit           exp_valid = 1'b0;

  fetch_stage #(
    .N        (64),
    .PC_INC   (64'd4),
    .RESET_PC (64'd0)
  ) fetch (
    .PCSrc_F     (PCSrc_F),
    .clk         (clk),
    .reset       (reset),
    .PCBranch_F  (PCBranch_F),
    .imem_addr_F (imem_addr_F)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the PC must be after each edge, then checked 1 ns later.
  always @(posedge clk) begin
    if (reset) begin
      exp_pc    = '0;
      exp_valid = 1'b1;
    end else if (exp_valid) begin
      exp_pc = PCSrc_F ? PCBranch_F : exp_pc + 64'd4;
    end
    #1;
    if (exp_valid) begin
      checks++;
      if (imem_addr_F !== exp_pc) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, imem_addr_F, exp_pc);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [W-1:0] b);
    @(negedge clk);
    reset      = r;
    PCSrc_F    = s;
    PCBranch_F = b;
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] want);
    checks++;
    if (imem_addr_F !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, imem_addr_F, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] br;
    reset      = 1'b1;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      check_lit("reset_hold", 64'd0);
    end

    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, '0);
      check_lit("seq_count", 64'(4 * i));
    end

    step(1'b0, 1'b1, '0);
    check_lit("branch_zero", 64'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, '0);
      check_lit("seq_after_branch", 64'(4 * i));
    end

    step(1'b0, 1'b1, 64'h1000);
    check_lit("branch_1000", 64'h1000);
    step(1'b0, 1'b0, 64'h1000);
    check_lit("seq_1004", 64'h1004);

    step(1'b1, 1'b1, 64'h40);
    check_lit("reset_priority", 64'd0);
    step(1'b0, 1'b0, 64'h40);
    check_lit("after_reset_prio", 64'd4);

    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_lit("branch_top", 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, '0);
    check_lit("wrap_zero", 64'd0);

    step(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF3);
    check_lit("unaligned_branch", 64'h1234_5678_9ABC_DEF3);
    step(1'b0, 1'b0, '0);
    check_lit("unaligned_inc", 64'h1234_5678_9ABC_DEF7);
    step(1'b1, 1'b0, '0);
    check_lit("mid_reset", 64'd0);
    step(1'b0, 1'b0, '0);
    check_lit("resume_count", 64'd4);

    for (int i = 0; i < 400; i++) begin
      br = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) br = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), br);
    end

    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
